mult_datapath: RTL and testbench

- Shift-and-add signed multiplier datapath. It is the responder to the multiplier control unit.
- It captures two signed operands on `load`. On each `enable` step it adds the shifted multiplicand to the accumulator when `Psel` is asserted.
- It reports `b0` (current multiplier LSB) and `z_flag` (multiplier exhausted) back to the control unit.
- Its signed product feeds the BCD display path.

---
 rtl/mult_datapath.sv | 127 ++++++++++++
 tb/tb_mult_datapath.sv | 258 +++++++++++++++++++++++++
 2 files changed

// File: rtl/mult_datapath.sv
// Shift-and-add signed multiplier datapath.
// Works on operand magnitudes and applies the result sign at the output.
// The external control unit sequences it with load / enable / Psel and
// watches b0 and z_flag to decide whether each step should add.
module mult_datapath #(
    parameter int WIDTH = 8,
    parameter int CNT_W = 4
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 load,
    input  logic                 enable,
    input  logic                 Psel,
    input  logic [WIDTH-1:0]     a_in,
    input  logic [WIDTH-1:0]     b_in,
    output logic                 b0,
    output logic                 z_flag,
    output logic [2*WIDTH-1:0]   product,
    output logic                 sign,
    output logic                 busy,
    output logic [CNT_W-1:0]     step_count,
    output logic                 psel_err
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t               state;
    state_t               state_next;
    logic [2*WIDTH-1:0]   mc;       // multiplicand magnitude, shifted left each step
    logic [WIDTH-1:0]     mp;       // multiplier magnitude, shifted right each step
    logic [2*WIDTH-1:0]   acc;      // unsigned partial product
    logic                 sign_r;   // sign of the final product
    logic [CNT_W-1:0]     cnt;

    logic                 mp_zero;
    logic                 step_en;
    logic                 add_en;
    logic                 err_set;

    // Two's complement magnitude; the most negative value maps to 2^(WIDTH-1)
    // because the result is read back as unsigned.
    function automatic logic [WIDTH-1:0] mag(input logic [WIDTH-1:0] x);
        return x[WIDTH-1] ? -x : x;
    endfunction

    // A load always wins over a step in the same cycle.
    assign mp_zero = (mp == '0);
    assign step_en = (state == S_RUN) && enable && !load && !mp_zero;
    assign add_en  = step_en && Psel && mp[0];
    assign err_set = (state == S_RUN) && enable && !load && Psel && !mp[0];

    // State register.
    always_ff @(posedge clk) begin
        // NOTE: clocked state uses non-blocking assignments so every register
        // samples the pre-edge values regardless of statement order.
        if (reset) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic: RUN falls through to DONE once the multiplier is used up.
    always_comb begin
        // NOTE: default assignment first so no path leaves state_next unassigned
        // and no latch is inferred.
        state_next = state;
        case (state)
            S_IDLE: if (load) state_next = S_RUN;
            S_RUN: begin
                if (load) begin
                    state_next = S_RUN;
                end else if (mp_zero) begin
                    state_next = S_DONE;
                end
            end
            S_DONE: if (load) state_next = S_RUN;
            default: state_next = S_IDLE;
        endcase
    end

    // Operand capture and shift/add step.
    always_ff @(posedge clk) begin
        if (reset) begin
            mc     <= '0;
            mp     <= '0;
            acc    <= '0;
            sign_r <= 1'b0;
            cnt    <= '0;
        end else if (load) begin
            mc     <= {{WIDTH{1'b0}}, mag(a_in)};
            mp     <= mag(b_in);
            acc    <= '0;
            sign_r <= a_in[WIDTH-1] ^ b_in[WIDTH-1];
            cnt    <= '0;
        end else if (step_en) begin
            if (add_en) begin
                acc <= acc + mc;
            end
            mc  <= mc << 1;
            mp  <= mp >> 1;
            cnt <= (cnt < CNT_W'(WIDTH)) ? cnt + CNT_W'(1) : cnt;
        end
    end

    // Sticky protocol error: Psel asked for an add while the multiplier LSB was 0.
    always_ff @(posedge clk) begin
        if (reset) begin
            psel_err <= 1'b0;
        end else if (err_set) begin
            psel_err <= 1'b1;
        end
    end

    assign busy       = (state == S_RUN);
    assign b0         = (state != S_IDLE) && mp[0];
    assign z_flag     = (state != S_IDLE) && mp_zero;
    assign step_count = cnt;
    assign product    = sign_r ? -acc : acc;
    // A zero result is always reported as positive.
    assign sign       = sign_r && (acc != '0);

endmodule

// File: tb/tb_mult_datapath.sv
// Self-checking bench for mult_datapath: a cycle model built from
// "operand magnitudes + number of shifts taken" is compared against the DUT
// every cycle after reset, plus literal expectations from the test plan.
module tb_mult_datapath;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        load = 1'b0;
    logic        enable = 1'b0;
    logic        Psel = 1'b0;
    logic [7:0]  a_in = '0;
    logic [7:0]  b_in = '0;
    logic        b0;
    logic        z_flag;
    logic [15:0] product;
    logic        sign;
    logic        busy;
    logic [3:0]  step_count;
    logic        psel_err;

    int errors = 0;
    int checks = 0;

    mult_datapath #(.WIDTH(8), .CNT_W(4)) dut (
        .clk        (clk),
        .reset      (reset),
        .load       (load),
        .enable     (enable),
        .Psel       (Psel),
        .a_in       (a_in),
        .b_in       (b_in),
        .b0         (b0),
        .z_flag     (z_flag),
        .product    (product),
        .sign       (sign),
        .busy       (busy),
        .step_count (step_count),
        .psel_err   (psel_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int absv(input logic [7:0] x);
        int v;
        v = $signed(x);
        return (v < 0) ? -v : v;
    endfunction

    // ---------------- behavioural model ----------------
    typedef enum {P_IDLE, P_RUN, P_DONE} phase_t;
    phase_t m_phase = P_IDLE;
    bit     m_valid = 1'b0;
    int     m_amag = 0, m_bmag = 0, m_shift = 0, m_acc = 0, m_cnt = 0;
    bit     m_sign = 1'b0, m_err = 1'b0;

    // Multiplier remaining = |b| >> shifts; multiplicand = |a| << shifts.
    always @(posedge clk) begin : model
        int mp_now;
        int mc_now;
        mp_now = m_bmag >> m_shift;
        mc_now = m_amag << m_shift;
        if (reset) begin
            m_valid <= 1'b1;
            m_phase <= P_IDLE;
            m_amag  <= 0;
            m_bmag  <= 0;
            m_shift <= 0;
            m_acc   <= 0;
            m_cnt   <= 0;
            m_sign  <= 1'b0;
            m_err   <= 1'b0;
        end else if (load) begin
            m_phase <= P_RUN;
            m_amag  <= absv(a_in);
            m_bmag  <= absv(b_in);
            m_shift <= 0;
            m_acc   <= 0;
            m_cnt   <= 0;
            m_sign  <= a_in[7] ^ b_in[7];
        end else if (m_phase == P_RUN) begin
            if (enable && Psel && (mp_now % 2 == 0)) m_err <= 1'b1;
            if (enable && mp_now != 0) begin
                if (Psel && (mp_now % 2 == 1)) m_acc <= (m_acc + mc_now) % 65536;
                m_shift <= m_shift + 1;
                m_cnt   <= (m_cnt < 8) ? m_cnt + 1 : 8;
            end
            if (mp_now == 0) m_phase <= P_DONE;
        end
    end

    // Compare every cycle on the falling edge, once the model has seen reset.
    always @(negedge clk) begin : compare
        int          mp_now;
        logic [15:0] ep;
        if (m_valid) begin
            mp_now = m_bmag >> m_shift;
            ep = m_sign ? 16'(-m_acc) : 16'(m_acc);
            check("busy",       busy,       (m_phase == P_RUN));
            check("b0",         b0,         (m_phase != P_IDLE) && (mp_now % 2 == 1));
            check("z_flag",     z_flag,     (m_phase != P_IDLE) && (mp_now == 0));
            check("product",    product,    ep);
            check("sign",       sign,       m_sign && (m_acc != 0));
            check("step_count", step_count, m_cnt);
            check("psel_err",   psel_err,   m_err);
        end
    end

    // ---------------- stimulus ----------------
    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1; load = 1'b0; enable = 1'b0; Psel = 1'b0;
        tick();
        tick();
        reset = 1'b0;
    endtask

    task automatic do_load(input logic [7:0] a, input logic [7:0] b);
        a_in = a; b_in = b; load = 1'b1; enable = 1'b0; Psel = 1'b0;
        tick();
        load = 1'b0;
    endtask

    int bseq[20];
    int steps_done;

    // Step with Psel following b0 until z_flag, then let it settle into DONE.
    task automatic run_to_done();
        steps_done = 0;
        while (!z_flag && steps_done < 20) begin
            bseq[steps_done] = b0;
            enable = 1'b1;
            Psel   = b0;
            tick();
            steps_done++;
        end
        enable = 1'b0;
        Psel   = 1'b0;
        check("step_bound", (steps_done < 20), 1);
        for (int i = 0; i < 4 && busy; i++) tick();
        check("reached_done", busy, 0);
    endtask

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
        $fatal(1, "timeout");
    end

    initial begin : stim
        tick();
        // 1: IDLE ignores enable
        do_reset();
        enable = 1'b1;
        for (int i = 0; i < 5; i++) tick();
        enable = 1'b0;
        check("t1_busy", busy, 0);
        check("t1_z", z_flag, 0);
        check("t1_b0", b0, 0);
        check("t1_product", product, 16'h0000);
        check("t1_count", step_count, 0);

        // 2: 6 * 5
        do_load(8'd6, 8'd5);
        check("t2_busy", busy, 1);
        run_to_done();
        check("t2_steps", steps_done, 3);
        check("t2_b0_s0", bseq[0], 1);
        check("t2_b0_s1", bseq[1], 0);
        check("t2_b0_s2", bseq[2], 1);
        check("t2_product", product, 16'd30);
        check("t2_sign", sign, 0);
        check("t2_count", step_count, 3);
        check("t2_z", z_flag, 1);

        // 3: -128 * -1
        do_load(8'h80, 8'hFF);
        run_to_done();
        check("t3_product", product, 16'h0080);
        check("t3_sign", sign, 0);

        // 4: 7 * -3, then 0 * -3
        do_load(8'd7, 8'hFD);
        run_to_done();
        check("t4_product", product, 16'hFFEB);
        check("t4_sign", sign, 1);
        do_load(8'd0, 8'hFD);
        run_to_done();
        check("t4_zero_product", product, 16'h0000);
        check("t4_zero_sign", sign, 0);

        // 5: protocol error, sticky across load
        do_load(8'd3, 8'd2);
        check("t5_b0_before", b0, 0);
        enable = 1'b1; Psel = 1'b1;
        tick();
        enable = 1'b0; Psel = 1'b0;
        check("t5_err", psel_err, 1);
        check("t5_product", product, 16'h0000);
        check("t5_b0_after", b0, 1);
        check("t5_z_after", z_flag, 0);
        do_load(8'd5, 8'd5);
        check("t5_err_sticky", psel_err, 1);
        do_reset();
        check("t5_err_cleared", psel_err, 0);

        // 6a: load and enable together mid-run
        do_load(8'd6, 8'd5);
        enable = 1'b1; Psel = b0;
        tick();
        check("t6_count_mid", step_count, 1);
        a_in = 8'd9; b_in = 8'd3; load = 1'b1; enable = 1'b1; Psel = 1'b1;
        tick();
        load = 1'b0; enable = 1'b0; Psel = 1'b0;
        check("t6_count_reload", step_count, 0);
        check("t6_product_reload", product, 16'h0000);
        check("t6_b0_reload", b0, 1);
        // 6b: reset mid-run
        enable = 1'b1; Psel = b0;
        tick();
        enable = 1'b0; Psel = 1'b0;
        check("t6_product_partial", product, 16'd9);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("t6_rst_busy", busy, 0);
        check("t6_rst_product", product, 16'h0000);
        check("t6_rst_b0", b0, 0);
        check("t6_rst_z", z_flag, 0);
        check("t6_rst_count", step_count, 0);
        // 6c: DONE ignores enable
        do_load(8'd2, 8'd3);
        run_to_done();
        enable = 1'b1; Psel = 1'b1;
        for (int i = 0; i < 3; i++) tick();
        enable = 1'b0; Psel = 1'b0;
        check("t6_done_product", product, 16'd6);
        check("t6_done_count", step_count, 2);
        check("t6_done_busy", busy, 0);
        check("t6_done_err", psel_err, 0);

        tick();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
